// File: rtl/edge_gen_moore.sv
// Moore edge generator: drives o_q with requested rising/falling edges and enforces a dwell window.
// Define EDGE_GEN_CNT_EN to add the wrapping edge counter output o_edge_cnt.
module edge_gen_moore #(
    parameter int HOLD_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_req_v,
    input  logic              in_req_rise,
    input  logic [HOLD_W-1:0] in_hold,
    output logic              o_req_rdy,
    output logic              o_q,
    output logic              o_edge_p,
    output logic              o_err
`ifdef EDGE_GEN_CNT_EN
    ,
    output logic [CNT_W-1:0]  o_edge_cnt
`endif
);

    // Encodings 1xx are unused and fall back to IDLE_L.
    typedef enum logic [2:0] {
        IDLE_L = 3'b000,
        IDLE_H = 3'b001,
        HOLD_L = 3'b010,
        HOLD_H = 3'b011
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] dwell;
    logic              accept;
    logic              flip;

    function automatic logic [HOLD_W-1:0] dwell_dec(input logic [HOLD_W-1:0] d);
        return (d == '0) ? '0 : d - HOLD_W'(1);
    endfunction

    assign o_req_rdy = (state == IDLE_L) || (state == IDLE_H);
    assign accept    = in_req_v && o_req_rdy;
    assign flip      = accept && (((state == IDLE_L) &&  in_req_rise) ||
                                  ((state == IDLE_H) && !in_req_rise));

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state    <= IDLE_L;
            dwell    <= '0;
            o_q      <= 1'b0;
            o_edge_p <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            o_edge_p <= 1'b0;
            o_err    <= 1'b0;
            case (state)
                IDLE_L: begin
                    if (flip) begin
                        state    <= HOLD_H;
                        o_q      <= 1'b1;
                        o_edge_p <= 1'b1;
                        dwell    <= in_hold;
                    end else if (accept) begin
                        o_err    <= 1'b1;
                    end
                end
                IDLE_H: begin
                    if (flip) begin
                        state    <= HOLD_L;
                        o_q      <= 1'b0;
                        o_edge_p <= 1'b1;
                        dwell    <= in_hold;
                    end else if (accept) begin
                        o_err    <= 1'b1;
                    end
                end
                HOLD_L: begin
                    if (dwell == '0) state <= IDLE_L;
                    else             dwell <= dwell_dec(dwell);
                end
                HOLD_H: begin
                    if (dwell == '0) state <= IDLE_H;
                    else             dwell <= dwell_dec(dwell);
                end
                default: begin
                    state <= IDLE_L;
                    o_q   <= 1'b0;
                    dwell <= '0;
                end
            endcase
        end
    end

`ifdef EDGE_GEN_CNT_EN
    // Advances on the same clock edge that launches o_edge_p.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n)  o_edge_cnt <= '0;
        else if (flip)  o_edge_cnt <= o_edge_cnt + CNT_W'(1);
    end
`else
    // Edge counter not built in this configuration.
`endif

endmodule

// File: tb/tb_edge_gen_moore.sv
// Directed self-checking bench for edge_gen_moore; expected values are hand-derived per step.
module tb_edge_gen_moore;

    localparam int HOLD_W = 4;
    localparam int CNT_W  = 8;

    logic              in_clk;
    logic              in_rst_n;
    logic              in_req_v;
    logic              in_req_rise;
    logic [HOLD_W-1:0] in_hold;
    logic              o_req_rdy;
    logic              o_q;
    logic              o_edge_p;
    logic              o_err;
`ifdef EDGE_GEN_CNT_EN
    logic [CNT_W-1:0]  o_edge_cnt;
`endif

    int n_pass;
    int n_total;

    edge_gen_moore #(.HOLD_W(HOLD_W), .CNT_W(CNT_W)) dut (
        .in_clk      (in_clk),
        .in_rst_n    (in_rst_n),
        .in_req_v    (in_req_v),
        .in_req_rise (in_req_rise),
        .in_hold     (in_hold),
        .o_req_rdy   (o_req_rdy),
        .o_q         (o_q),
        .o_edge_p    (o_edge_p),
        .o_err       (o_err)
`ifdef EDGE_GEN_CNT_EN
        ,
        .o_edge_cnt  (o_edge_cnt)
`endif
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one rising edge, then sample 1 ns later.
    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic q, input logic rdy, input logic ep, input logic er);
        chk({tag, ".q"},   o_q,       q);
        chk({tag, ".rdy"}, o_req_rdy, rdy);
        chk({tag, ".ep"},  o_edge_p,  ep);
        chk({tag, ".err"}, o_err,     er);
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        in_rst_n    = 1'b0;
        in_req_v    = 1'b0;
        in_req_rise = 1'b0;
        in_hold     = '0;
        #1;
        chk_all("rst_async", 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        step();
        in_rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step();
            chk_all("idle", 1'b0, 1'b1, 1'b0, 1'b0);
        end
`ifdef EDGE_GEN_CNT_EN
        chk("cnt_reset", 32'(o_edge_cnt), 32'd0);
`endif

        // Rise with hold=3: rdy low for 4 cycles
        in_req_v = 1'b1; in_req_rise = 1'b1; in_hold = 4'd3;
        step();
        chk_all("rise_n", 1'b1, 1'b0, 1'b1, 1'b0);
        in_req_v = 1'b0; in_hold = 4'd9; in_req_rise = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk_all("rise_dwell", 1'b1, 1'b0, 1'b0, 1'b0);
        end
        step();
        chk_all("rise_n4", 1'b1, 1'b1, 1'b0, 1'b0);

        // Same-direction rise while high
        in_req_v = 1'b1; in_req_rise = 1'b1;
        step();
        chk_all("err_rise_hi", 1'b1, 1'b1, 1'b0, 1'b1);

        // Back-to-back toggles with hold=0, req_v held high
        in_req_rise = 1'b0; in_hold = 4'd0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk_all("tog_edge", logic'(k % 2), 1'b0, 1'b1, 1'b0);
            in_req_rise = ~in_req_rise;
            step();
            chk_all("tog_gap", logic'(k % 2), 1'b1, 1'b0, 1'b0);
        end

        // Get to low level, then fall request while low
        in_req_rise = 1'b0;
        step();
        chk_all("to_low", 1'b0, 1'b0, 1'b1, 1'b0);
        in_req_v = 1'b0;
        step();
        chk_all("to_low_idle", 1'b0, 1'b1, 1'b0, 1'b0);
        in_req_v = 1'b1; in_req_rise = 1'b0;
        step();
        chk_all("err_fall_lo", 1'b0, 1'b1, 1'b0, 1'b1);
        in_req_v = 1'b0;
        step();
        chk_all("err_clear", 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset mid-dwell with counter at 5
        in_req_v = 1'b1; in_req_rise = 1'b1; in_hold = 4'd9;
        step();
        chk_all("pre_rst_edge", 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step();
        chk_all("pre_rst_dwell", 1'b1, 1'b0, 1'b0, 1'b0);
        #3;
        in_rst_n = 1'b0;
        #1;
        chk_all("rst_mid", 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("rst_req_ign", 1'b0, 1'b1, 1'b0, 1'b0);
        in_rst_n = 1'b0;
        in_hold = 4'd0;
        #2;
        in_rst_n = 1'b1;
        step();
        chk_all("post_rst_rise", 1'b1, 1'b0, 1'b1, 1'b0);
        in_req_v = 1'b0;
        step();
        chk_all("post_rst_idle", 1'b1, 1'b1, 1'b0, 1'b0);

        // Return low, then hold=15 rise with fall pending during dwell
        in_req_v = 1'b1; in_req_rise = 1'b0; in_hold = 4'd0;
        step();
        in_req_v = 1'b0;
        step();
        chk_all("low_again", 1'b0, 1'b1, 1'b0, 1'b0);
        in_req_v = 1'b1; in_req_rise = 1'b1; in_hold = 4'd15;
        step();
        chk_all("max_rise", 1'b1, 1'b0, 1'b1, 1'b0);
        in_req_rise = 1'b0; in_hold = 4'd0;
        for (int i = 1; i <= 15; i++) begin
            step();
            chk_all("max_dwell", 1'b1, 1'b0, 1'b0, 1'b0);
        end
        step();
        chk_all("max_rdy", 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk_all("max_fall", 1'b0, 1'b0, 1'b1, 1'b0);
        in_req_v = 1'b0;
        step();
        chk_all("max_fall_after", 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef EDGE_GEN_CNT_EN
        // 300 edges from reset wrap the 8-bit counter to 44
        in_rst_n = 1'b0;
        #2;
        in_rst_n = 1'b1;
        chk("cnt_rst", 32'(o_edge_cnt), 32'd0);
        in_req_v = 1'b1; in_req_rise = 1'b1; in_hold = 4'd0;
        for (int k = 0; k < 300; k++) begin
            step();
            in_req_rise = ~in_req_rise;
            step();
        end
        chk("cnt_300", 32'(o_edge_cnt), 32'd44);
        in_req_v = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/edge_gen_moore.md
Name: edge_gen_moore

Overview:
Edge generator (transmit side of the edge-detection path): it drives a single-bit line o_q and produces a rising or falling transition on request. Requests use a valid/ready handshake. After each edge, a programmable minimum dwell time is enforced before the next request is accepted. It is a Moore FSM with registered outputs, and it feeds edge-detector blocks and their testbenches.

Parameters:
HOLD_W, 4, width of dwell-time input and internal dwell counter
CNT_W, 8, width of edge counter (used only with EDGE_GEN_CNT_EN)

Ports:
in_clk  input  1  clock, all state changes on rising edge
in_rst_n  input  1  asynchronous active-low reset
in_req_v  input  1  edge request valid
in_req_rise  input  1  requested direction: 1=rising (0->1), 0=falling (1->0)
in_hold  input  HOLD_W  dwell cycles after the edge; sampled only on accept
o_req_rdy  output  1  ready to accept a request (Moore, state-decoded)
o_q  output  1  generated line, registered
o_edge_p  output  1  one-cycle pulse in the cycle the new o_q level first appears
o_err  output  1  one-cycle pulse: accepted request matched current level, no edge made
o_edge_cnt  output  CNT_W  edge counter; present only with EDGE_GEN_CNT_EN

Behaviour:
- States: IDLE_L, IDLE_H, HOLD_L, HOLD_H. The suffix is the current o_q level.
- Reset (in_rst_n=0, async) forces:
  - state IDLE_L, o_q=0, o_edge_p=0, o_err=0
  - dwell counter=0, o_edge_cnt=0
  - Outputs take these values immediately, without waiting for a clock.
- Reset asserted mid-dwell aborts the dwell. Any request present during reset is ignored.
- o_req_rdy=1 only in IDLE_L and IDLE_H.
- Accept occurs when in_req_v=1 and o_req_rdy=1 at a rising in_clk edge.
- Accept in IDLE_L with in_req_rise=1, at edge N:
  - next state HOLD_H, o_q=1, o_edge_p=1 during cycle N..N+1
  - counter loaded with in_hold
- Accept in IDLE_H with in_req_rise=0: symmetric; next state HOLD_L, o_q=0.
- Same-direction request (rise in IDLE_H, or fall in IDLE_L):
  - the request is accepted (handshake completes)
  - state and o_q are unchanged, no dwell is started
  - o_err=1 for one cycle, o_edge_p=0
- HOLD_x:
  - if counter==0, next state is IDLE_x; otherwise counter decrements by 1
  - in_req_v is ignored (o_req_rdy=0)
  - o_q holds its level
- Timing:
  - o_req_rdy is low for exactly in_hold+1 cycles after an edge.
  - in_hold=0 gives back-to-back edges spaced 2 cycles apart.
  - in_hold=2^HOLD_W-1 is the maximum dwell; the counter does not wrap.
- o_edge_p and o_err are never high in the same cycle. Both are 0 in every cycle without an accept.
- The requester may change in_hold and in_req_rise freely while o_req_rdy=0; they have no effect until accept.
- Illegal state encodings recover to IDLE_L with o_q=0 on the next clock.

Optional Feature:
- Macro EDGE_GEN_CNT_EN.
- When defined:
  - port o_edge_cnt exists
  - it increments by 1 in the same cycle o_edge_p is asserted
  - it wraps modulo 2^CNT_W
  - it is unaffected by o_err requests and reset to 0 only by in_rst_n
- When undefined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, no requests:
  - o_q=0, o_req_rdy=1, o_edge_p=0, o_err=0 held for 10 cycles
  - o_edge_cnt=0
- Rise request, in_hold=3, accepted at edge N:
  - o_q=1 and o_edge_p=1 from N
  - o_req_rdy=0 for cycles N..N+3, 1 at N+4
  - o_edge_p=0 from N+1
- in_req_v held high and alternating rise/fall, in_hold=0:
  - o_q toggles every 2 cycles
  - each toggle has exactly one o_edge_p pulse
  - with EDGE_GEN_CNT_EN, after 300 edges o_edge_cnt=44 (300 mod 256)
- Fall request while o_q=0:
  - accepted in 1 cycle, o_err=1 for one cycle
  - o_q stays 0, o_edge_p=0, o_req_rdy stays 1
- in_rst_n pulsed low mid-dwell (o_q=1, counter=5):
  - o_q=0 and o_req_rdy=1 asynchronously, before the next clock
  - the next rise request produces a normal edge
- in_hold=15 (HOLD_W=4) rise, then a fall request asserted during the dwell:
  - fall is not accepted until 16 cycles after the rise
  - then o_q=0 with one o_edge_p pulse
